cart_loader: RTL and testbench

UART-driven cartridge image loader sitting upstream of the 8 KB cartridge memory on the Nexys4 C64 top level. It parses length-prefixed frames from the debug UART receiver and writes the payload into the cartridge RAM write port. It holds the C64 in reset while loading and flags a valid cartridge image after a good transfer. It answers each frame with an ACK or NAK byte through the UART transmitter.

---
 rtl/cart_loader_pkg.sv | 23 ++
 rtl/cart_loader_timer.sv | 29 ++
 rtl/cart_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_cart_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cart_loader_pkg.sv
// Shared types and constants for the UART cartridge image loader.
package cart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RESP   = 3'd5,
    ST_HOLD   = 3'd6
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'h4C;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // Running 8-bit payload checksum, wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/cart_loader_timer.sv
// Reloadable down-counter; expired_o is high whenever the count has reached zero.
module cart_loader_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] r_cnt;

  // Count down to zero and stick there; a load always wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= value_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired_o = (r_cnt == '0);

endmodule

// File: rtl/cart_loader.sv
// Frame parser writing a UART-delivered cartridge image into cartridge RAM.
// Define CART_LOADER_CHECKSUM_EN to require a trailing checksum byte per frame.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int DEPTH          = 8192,
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int RESET_HOLD     = 1024
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_valid_i,
  output logic [7:0]        tx_byte_o,
  output logic              tx_valid_o,
  input  logic              tx_busy_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              c64_reset_o,
  output logic              cart_valid_o,
  output logic              busy_o
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > RESET_HOLD) ? TIMEOUT_CYCLES : RESET_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // Loaded with N-1 so expiry is observed exactly N cycles after the load edge.
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RESET_HOLD - 1);
  localparam logic [16:0]      DEPTH_L   = 17'(DEPTH);

  state_e            r_state, w_state_nxt;
  logic [15:0]       r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [7:0]        r_resp, w_resp_nxt;
  logic [7:0]        r_tx_byte, w_tx_byte_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]        r_mem_data, w_mem_data_nxt;
  logic              r_c64_reset, w_c64_reset_nxt;
  logic              r_cart_valid, w_cart_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_tmr_load, w_expired;
  logic [TMR_W-1:0]  w_tmr_value;
  logic [15:0]       w_len_full;
  logic              w_last;

  assign w_len_full = {rx_byte_i, r_len[7:0]};
  assign w_last     = (16'(r_addr) == (r_len - 16'd1));

  cart_loader_timer #(.W(TMR_W)) u_timer (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .load_i    (w_tmr_load),
    .value_i   (w_tmr_value),
    .expired_o (w_expired)
  );

  // Next-state and next-output decode for the frame parser.
  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_addr_nxt       = r_addr;
    w_sum_nxt        = r_sum;
    w_resp_nxt       = r_resp;
    w_tx_byte_nxt    = r_tx_byte;
    w_tx_valid_nxt   = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_data_nxt   = r_mem_data;
    w_c64_reset_nxt  = r_c64_reset;
    w_cart_valid_nxt = r_cart_valid;
    w_tmr_load       = 1'b0;
    w_tmr_value      = TO_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid_i && (rx_byte_i == HDR_BYTE)) begin
          w_state_nxt      = ST_LEN_LO;
          w_c64_reset_nxt  = 1'b1;
          w_cart_valid_nxt = 1'b0;
          w_tmr_load       = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid_i) begin
          w_len_nxt   = {r_len[15:8], rx_byte_i};
          w_state_nxt = ST_LEN_HI;
          w_tmr_load  = 1'b1;
        end else if (w_expired) begin
          w_resp_nxt  = NAK_BYTE;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid_i) begin
          w_len_nxt  = w_len_full;
          w_tmr_load = 1'b1;
          if ((w_len_full == 16'd0) || ({1'b0, w_len_full} > DEPTH_L)) begin
            w_resp_nxt  = NAK_BYTE;
            w_state_nxt = ST_RESP;
          end else begin
            w_addr_nxt  = '0;
            w_sum_nxt   = 8'd0;
            w_state_nxt = ST_DATA;
          end
        end else if (w_expired) begin
          w_resp_nxt  = NAK_BYTE;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (rx_valid_i) begin
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = r_addr;
          w_mem_data_nxt = rx_byte_i;
          w_sum_nxt      = csum_add(r_sum, rx_byte_i);
          w_tmr_load     = 1'b1;
          // Counter stops on the last byte so it never passes DEPTH-1.
          if (w_last) begin
`ifdef CART_LOADER_CHECKSUM_EN
            w_state_nxt = ST_CSUM;
`else
            w_resp_nxt  = ACK_BYTE;
            w_state_nxt = ST_RESP;
`endif
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end else if (w_expired) begin
          w_resp_nxt  = NAK_BYTE;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef CART_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid_i) begin
          w_resp_nxt  = (rx_byte_i == r_sum) ? ACK_BYTE : NAK_BYTE;
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_resp_nxt  = NAK_BYTE;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_CSUM;
        end
      end
`endif
      ST_RESP: begin
        if (!tx_busy_i) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_byte_nxt  = r_resp;
          if (r_resp == ACK_BYTE) begin
            w_state_nxt      = ST_HOLD;
            w_cart_valid_nxt = 1'b1;
            w_tmr_load       = 1'b1;
            w_tmr_value      = HOLD_LOAD;
          end else begin
            w_state_nxt     = ST_IDLE;
            w_c64_reset_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_HOLD: begin
        if (w_expired) begin
          w_state_nxt     = ST_IDLE;
          w_c64_reset_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_c64_reset_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_len        <= 16'd0;
      r_addr       <= '0;
      r_sum        <= 8'd0;
      r_resp       <= 8'd0;
      r_tx_byte    <= 8'd0;
      r_tx_valid   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= 8'd0;
      r_c64_reset  <= 1'b0;
      r_cart_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_addr       <= w_addr_nxt;
      r_sum        <= w_sum_nxt;
      r_resp       <= w_resp_nxt;
      r_tx_byte    <= w_tx_byte_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_data   <= w_mem_data_nxt;
      r_c64_reset  <= w_c64_reset_nxt;
      r_cart_valid <= w_cart_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign tx_byte_o    = r_tx_byte;
  assign tx_valid_o   = r_tx_valid;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign c64_reset_o  = r_c64_reset;
  assign cart_valid_o = r_cart_valid;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader: expected RAM writes and response bytes are
// queued as frames are driven and popped as the DUT produces them.
module tb_cart_loader;

  localparam int ADDR_W     = 13;
  localparam int TIMEOUT    = 100;
  localparam int HOLD       = 1024;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic              clk = 1'b0;
  logic              rstn_i = 1'b0;
  logic [7:0]        rx_byte_i = 8'd0;
  logic              rx_valid_i = 1'b0;
  logic [7:0]        tx_byte_o;
  logic              tx_valid_o;
  logic              tx_busy_i = 1'b0;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_o;
  logic              c64_reset_o;
  logic              cart_valid_o;
  logic              busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int tx_cnt = 0;
  logic [ADDR_W+7:0] exp_wr[$];
  logic [7:0]        exp_tx[$];

  cart_loader #(
    .ADDR_W(ADDR_W), .DEPTH(8192), .TIMEOUT_CYCLES(TIMEOUT), .RESET_HOLD(HOLD)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i),
    .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_busy_i(tx_busy_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .c64_reset_o(c64_reset_o), .cart_valid_o(cart_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rstn_i) begin
      if (mem_we_o) begin
        if (exp_wr.size() == 0) check_val("wr_unexpected", 32'(mem_we_o), 32'd0);
        else check_val("wr_addr_data", 32'({mem_addr_o, mem_data_o}), 32'(exp_wr.pop_front()));
      end
      if (tx_valid_o) begin
        tx_cnt++;
        check_val("tx_while_busy", 32'(tx_busy_i), 32'd0);
        if (exp_tx.size() == 0) check_val("tx_unexpected", 32'(tx_valid_o), 32'd0);
        else check_val("tx_byte", 32'(tx_byte_o), 32'(exp_tx.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len);
    send_byte(8'h4C);
    check_val("hdr_c64_reset", 32'(c64_reset_o), 32'd1);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  // Full frame with payload seed, seed+1, ...; queues expected writes and reply.
  task automatic send_frame(input int n, input logic [7:0] seed, input bit bad_sum, input bit ack);
    logic [7:0] sum;
    logic [7:0] d;
    sum = 8'd0;
    exp_tx.push_back(ack ? ACK : NAK);
    send_len(16'(n));
    for (int i = 0; i < n; i++) begin
      d   = seed + 8'(i);
      sum = sum + d;
      exp_wr.push_back({ADDR_W'(i), d});
      send_byte(d);
    end
    sum = sum + (bad_sum ? 8'd1 : 8'd0);
`ifdef CART_LOADER_CHECKSUM_EN
    send_byte(sum);
`endif
  endtask

  task automatic wait_tx(input string tag, input int prev, input int budget, output int k);
    k = 0;
    while ((tx_cnt == prev) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(tx_cnt != prev), 32'd1);
  endtask

  // Called on the tx_valid_o cycle; measures cycles until c64_reset_o drops.
  task automatic wait_hold(input string tag);
    int k;
    k = 0;
    while (c64_reset_o && (k < HOLD + 50)) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(k), 32'(HOLD));
    check_val({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog tx_cnt=%0d exp=done", tx_cnt);
    $fatal(1);
  end

  initial begin
    int prev;
    int k;
    repeat (3) @(negedge clk);
    check_val("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_val("rst_outputs", 32'({tx_byte_o, mem_we_o, mem_addr_o, mem_data_o}), 32'd0);
    check_val("rst_flags", 32'({c64_reset_o, cart_valid_o, busy_o}), 32'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame 01 02 03 04 (checksum 0A).
    prev = tx_cnt;
    send_frame(4, 8'h01, 1'b0, 1'b1);
    wait_tx("ack1_seen", prev, 10, k);
    check_val("ack1_cart_valid", 32'(cart_valid_o), 32'd1);
    check_val("ack1_busy", 32'(busy_o), 32'd1);
    wait_hold("ack1_hold");

`ifdef CART_LOADER_CHECKSUM_EN
    // Same frame, checksum 0B.
    prev = tx_cnt;
    send_frame(4, 8'h01, 1'b1, 1'b0);
    wait_tx("nak_csum_seen", prev, 10, k);
    check_val("nak_csum_cart_valid", 32'(cart_valid_o), 32'd0);
    k = 0;
    while (c64_reset_o && (k < 3)) begin
      @(negedge clk);
      k++;
    end
    check_val("nak_csum_rst_fall", 32'(c64_reset_o), 32'd0);
    check_val("nak_csum_rst_lat_le2", 32'(k <= 2), 32'd1);
`else
    // Payload whose sum wraps; loads and ACKs without a checksum byte.
    prev = tx_cnt;
    send_frame(3, 8'hF0, 1'b0, 1'b1);
    wait_tx("ack_wrap_seen", prev, 10, k);
    check_val("ack_wrap_cart_valid", 32'(cart_valid_o), 32'd1);
    wait_hold("ack_wrap_hold");
`endif

    // Oversize and zero lengths.
    prev = tx_cnt;
    exp_tx.push_back(NAK);
    send_len(16'h2001);
    wait_tx("nak_len_big_seen", prev, 4, k);
    check_val("nak_len_big_flags", 32'({c64_reset_o, cart_valid_o, busy_o}), 32'd0);
    prev = tx_cnt;
    exp_tx.push_back(NAK);
    send_len(16'h0000);
    wait_tx("nak_len_zero_seen", prev, 4, k);
    check_val("nak_len_zero_busy", 32'(busy_o), 32'd0);

    // Inter-byte timeout: LEN=2, one data byte, then silence.
    prev = tx_cnt;
    exp_tx.push_back(NAK);
    exp_wr.push_back({ADDR_W'(0), 8'h55});
    send_len(16'd2);
    send_byte(8'h55);
    wait_tx("nak_timeout_seen", prev, TIMEOUT + 50, k);
    check_val("nak_timeout_latency", 32'((k >= TIMEOUT) && (k <= TIMEOUT + 3)), 32'd1);
    check_val("nak_timeout_flags", 32'({c64_reset_o, cart_valid_o, busy_o}), 32'd0);

    // Transmitter busy at end of frame; bytes arriving meanwhile are dropped.
    prev = tx_cnt;
    tx_busy_i = 1'b1;
    send_frame(2, 8'hFE, 1'b0, 1'b1);
    send_byte(8'h4C);
    send_byte(8'h01);
    repeat (46) @(negedge clk);
    check_val("busy_tx_held", 32'(tx_cnt - prev), 32'd0);
    check_val("busy_still_busy", 32'(busy_o), 32'd1);
    tx_busy_i = 1'b0;
    wait_tx("busy_ack_seen", prev, 4, k);
    check_val("busy_ack_latency", 32'(k), 32'd1);
    wait_hold("busy_hold");

    // Asynchronous reset in the middle of DATA.
    exp_wr.push_back({ADDR_W'(0), 8'hAA});
    exp_wr.push_back({ADDR_W'(1), 8'hBB});
    send_len(16'd4);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    rstn_i = 1'b0;
    #1;
    check_val("async_rst_flags", 32'({c64_reset_o, cart_valid_o, busy_o}), 32'd0);
    check_val("async_rst_strobes", 32'({tx_valid_o, mem_we_o, mem_addr_o}), 32'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    prev = tx_cnt;
    send_frame(4, 8'h10, 1'b0, 1'b1);
    wait_tx("post_rst_ack_seen", prev, 10, k);
    check_val("post_rst_cart_valid", 32'(cart_valid_o), 32'd1);
    wait_hold("post_rst_hold");

    repeat (5) @(negedge clk);
    check_val("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check_val("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
